// File: rtl/hog_cell_histogram_if.sv
// Pixel-in / histogram-out bundle for hog_cell_histogram.
// master: upstream pixel source plus downstream histogram sink (the environment).
// slave : the histogram accumulator itself.
interface hog_cell_histogram_if #(
    parameter int NUM_BINS  = 9,
    parameter int BIN_IDX_W = 4,
    parameter int MAG_W     = 16,
    parameter int ACC_W     = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [MAG_W-1:0]          in_mag;
    logic [BIN_IDX_W-1:0]      in_bin;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_BINS*ACC_W-1:0] hist_out;
    logic                      ovf_flag;
    logic                      bad_bin;

    modport master (
        output in_valid, in_mag, in_bin, out_ready,
        input  in_ready, out_valid, hist_out, ovf_flag, bad_bin
    );

    modport slave (
        input  in_valid, in_mag, in_bin, out_ready,
        output in_ready, out_valid, hist_out, ovf_flag, bad_bin
    );
endinterface

// File: rtl/hog_cell_histogram.sv
// HOG cell histogram accumulator.
// Adds each accepted pixel magnitude into the bin chosen by its angle index.
// After CELL_PIXELS accepted pixels, the finished histogram is moved into a
// one-entry output register (valid/ready) and accumulation restarts at once.
// Optional build macro: HOG_HIST_SATURATE_EN -- per-bin adds saturate at
// 2^ACC_W-1 instead of wrapping; the carry is reported in ovf_flag either way.
module hog_cell_histogram #(
    parameter int NUM_BINS    = 9,
    parameter int BIN_IDX_W   = 4,
    parameter int MAG_W       = 16,
    parameter int ACC_W       = 16,
    parameter int CELL_PIXELS = 64,
    parameter int CNT_W       = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    hog_cell_histogram_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      out_valid_reg;
    logic                      ovf_flag_reg;
    logic                      bad_bin_reg;
    logic [NUM_BINS*ACC_W-1:0] hist_reg;

    logic                      in_ready_int;
    logic                      last_pixel;
    logic                      out_blocked;
    logic                      accept;
    logic                      cell_done;
    logic                      bin_ok;
    logic [NUM_BINS*ACC_W-1:0] acc_upd;
    logic [NUM_BINS-1:0]       bin_ovf;

    assign last_pixel  = (cnt_reg == CNT_W'(CELL_PIXELS - 1));
    // The output register is occupied and will not drain this cycle.
    assign out_blocked = out_valid_reg && !bus.out_ready;
    assign accept      = bus.in_valid && in_ready_int;
    assign cell_done   = accept && last_pixel;
    // Widened compare so NUM_BINS == 2^BIN_IDX_W does not truncate to zero.
    assign bin_ok      = ({1'b0, bus.in_bin} < (BIN_IDX_W + 1)'(NUM_BINS));

    // Next-state and in_ready decode; a low enable overrides everything.
    always_comb begin
        state_next   = state_reg;
        in_ready_int = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = ACCUM;
            end
            ACCUM: begin
                in_ready_int = !(last_pixel && out_blocked);
                if (last_pixel && out_blocked) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                // Last pixel goes in on the same edge the old histogram leaves.
                in_ready_int = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable) begin
            state_next   = IDLE;
            in_ready_int = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Per-bin accumulator, overflow tracker and add/saturate datapath.
    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
            logic [ACC_W-1:0] acc_reg;
            logic             ovf_reg;
            logic             hit;
            logic [ACC_W:0]   sum_full;
            logic [ACC_W-1:0] sum_val;
            logic             carry;

            assign hit      = accept && bin_ok && (bus.in_bin == BIN_IDX_W'(gi));
            assign sum_full = {1'b0, acc_reg} + {1'b0, ACC_W'(bus.in_mag)};
            assign carry    = hit && sum_full[ACC_W];
`ifdef HOG_HIST_SATURATE_EN
            assign sum_val  = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
            assign sum_val  = sum_full[ACC_W-1:0];
`endif
            // Bin value and overflow as they stand including this cycle's pixel.
            assign acc_upd[gi*ACC_W +: ACC_W] = hit ? sum_val : acc_reg;
            assign bin_ovf[gi]                = ovf_reg | carry;

            // Accumulate; clear on a finished cell or while disabled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (!enable || cell_done) begin
                    acc_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (hit) begin
                    acc_reg <= sum_val;
                    ovf_reg <= ovf_reg | carry;
                end
            end
        end
    endgenerate

    // Pixel counter within the current cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!enable || cell_done) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Output register: loaded on cell completion, drains even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg      <= '0;
            ovf_flag_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (cell_done) begin
            hist_reg      <= acc_upd;
            ovf_flag_reg  <= |bin_ovf;
            out_valid_reg <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Sticky out-of-range bin index flag, cleared by a disable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_bin_reg <= 1'b0;
        end else if (!enable) begin
            bad_bin_reg <= 1'b0;
        end else if (accept && !bin_ok) begin
            bad_bin_reg <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.hist_out  = hist_reg;
    assign bus.ovf_flag  = ovf_flag_reg;
    assign bus.bad_bin   = bad_bin_reg;

endmodule

// File: doc/hog_cell_histogram.md
Name: hog_cell_histogram

Overview:
- Parametrised gradient-orientation histogram accumulator for the HOG feature pipeline; sits between the magnitude/angle-bin stage and block normalisation.
- Accumulates the magnitude of each pixel into the bin selected by its angle index.
- After CELL_PIXELS accepted pixels, hands the completed cell histogram to a one-entry output register with valid/ready handshake, then clears and starts the next cell with no bubble.

Parameters:
- NUM_BINS, 9, number of orientation bins.
- BIN_IDX_W, 4, width of bin index input; must satisfy 2^BIN_IDX_W >= NUM_BINS.
- MAG_W, 16, unsigned magnitude width.
- ACC_W, 16, per-bin accumulator width; must be >= MAG_W.
- CELL_PIXELS, 64, pixels per cell, >= 1.
- CNT_W, 7, pixel counter width; must satisfy 2^CNT_W > CELL_PIXELS - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low = synchronous flush of the cell in progress.
- in_valid  input  1  pixel sample valid.
- in_ready  output  1  block can accept the sample.
- in_mag  input  MAG_W  gradient magnitude, unsigned.
- in_bin  input  BIN_IDX_W  orientation bin index.
- out_valid  output  1  completed cell histogram available.
- out_ready  input  1  downstream accepts the histogram.
- hist_out  output  NUM_BINS*ACC_W  bin 0 at LSBs, bin k at [k*ACC_W +: ACC_W].
- ovf_flag  output  1  sticky: some bin of the current output histogram overflowed.
- bad_bin  output  1  sticky: in_bin >= NUM_BINS was seen since reset or since the last disable.

Behaviour:
- Reset (rst_n low, async): all accumulators, pixel counter, hist_out, out_valid, ovf_flag and bad_bin go to 0. FSM goes to IDLE.
- FSM states:
  - IDLE: enable low. in_ready = 0. Accumulators, counter and bad_bin are held cleared. The output register and out_valid are kept, so a pending histogram can still drain.
  - ACCUM: enable high.
  - STALL: the last pixel of a cell is waiting for the output register to free.
- Transitions:
  - IDLE->ACCUM on enable = 1.
  - Any state -> IDLE on enable = 0, taking effect the next cycle. The partial cell is discarded with no out_valid.
- Accept: a pixel is accepted when in_valid && in_ready. The accepted magnitude is added to acc[in_bin] and the counter increments.
- in_bin >= NUM_BINS: the pixel is counted but not added to any bin, and bad_bin sets.
- in_ready:
  - High in ACCUM unless count == CELL_PIXELS-1 and out_valid && !out_ready; that case enters STALL.
  - In STALL, in_ready = out_ready, so the last pixel is accepted in the same cycle the old histogram drains. STALL then returns to ACCUM.
- Cell completion: when the accepted pixel is the last one (count == CELL_PIXELS-1), on that edge:
  - hist_out is loaded with the accumulators including this pixel's contribution.
  - ovf_flag is loaded with the OR of per-bin overflow, including this add.
  - out_valid goes to 1, the accumulators clear and the counter returns to 0.
  - Latency from last accepted pixel to out_valid is 1 cycle.
- Output handshake:
  - out_valid clears on out_valid && out_ready, unless a new cell completes in the same cycle, in which case it stays 1 with the new data.
  - hist_out is stable while out_valid && !out_ready.
- Arithmetic: unsigned add, with in_mag zero-extended to ACC_W. Overflow is the carry out of ACC_W.
- CELL_PIXELS = 1: every accepted pixel completes a cell.

Optional Feature:
- Macro HOG_HIST_SATURATE_EN.
- Defined: per-bin add saturates at 2^ACC_W - 1; overflow still raises ovf_flag.
- Undefined: per-bin add wraps modulo 2^ACC_W; ovf_flag still reports the carry.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cell after 10 pixels -> all outputs 0 immediately; after release with enable=1, a full 64-pixel cell yields out_valid with only the new pixels counted.
- Basic cell (defaults): 64 pixels, in_bin = i%9, in_mag=1, out_ready=1 -> one out_valid pulse 1 cycle after pixel 63; bin0 = 8 and bins 1-8 = 7, each read from hist_out; ovf_flag=0.
- Back-pressure: hold out_ready=0 and feed two cells back-to-back -> in_ready low on pixel 63 of cell 2; hist_out holds cell 1 values; raising out_ready for 1 cycle accepts the stalled pixel; out_valid stays 1 with cell 2 data the next cycle.
- Overflow: 64 pixels all bin 3 with in_mag=16'h0800 (sum 0x20000) -> ovf_flag=1. With macro defined, bin3 = 16'hFFFF. Without the macro, bin3 = 16'h0000.
- Bad bin and disable: in_bin=12 on pixel 5 -> bad_bin=1 and no bin changes, but the cell still completes at 64 pixels. Drop enable after 30 pixels -> no out_valid, in_ready=0, and the counter restarts from 0 on re-enable.
- Parametrised: NUM_BINS=18, ACC_W=20, CELL_PIXELS=1 -> each accepted pixel produces out_valid next cycle, with hist_out 360 bits wide and only in_bin's field non-zero.
